// File: rtl/onchip_memory_arbiter.sv
// rtl/onchip_memory_arbiter.sv - two-master round-robin arbiter with bounded hold in front of a single-port RAM
//
// Arbitrates two Avalon-MM masters onto one single-port on-chip RAM with a
// 1-cycle read latency. One transfer per clock, round-robin with a hold window
// of MAX_HOLD consecutive grants while the other master waits.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   m0_* / m1_*           master ports: address, byteenable, read, write,
//                         writedata in; waitrequest, readdata, readdatavalid out
//   mem_address/byteenable/chipselect/write/writedata
//                         RAM request side, driven on the grant cycle
//   mem_clken             RAM clock enable (low while mem_reset_req)
//   mem_reset_req         RAM reset request from the reset synchroniser
//   mem_readdata          RAM read data, valid the cycle after a read grant
module onchip_memory_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [1:0] rst_sync_q;
    logic       last_grant_q;
    logic [3:0] hold_cnt_q;
    logic       rd_vld_q;
    logic       rd_owner_q;
    logic       req0, req1;
    logic       grant0, grant1, grant_any;
    logic       sel_read, sel_write;

    // Reset assertion is immediate; release reaches the RAM two edges later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign mem_reset_req = ~rst_sync_q[1];
    assign mem_clken     = ~mem_reset_req;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Under contention the previous winner keeps the bus until it has used
    // MAX_HOLD consecutive grants, then the waiting master takes over.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!mem_reset_req) begin
            if (req0 && req1) begin
                if (hold_cnt_q < HOLD_MAX) begin
                    grant0 = ~last_grant_q;
                    grant1 = last_grant_q;
                end else begin
                    grant0 = last_grant_q;
                    grant1 = ~last_grant_q;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign grant_any = grant0 | grant1;
    assign sel_read  = grant1 ? m1_read  : m0_read;
    assign sel_write = grant1 ? m1_write : m0_write;

    // Reset values make m0 win the first contended cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            hold_cnt_q   <= HOLD_MAX;
            rd_vld_q     <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            if (grant_any) begin
                if (grant1 == last_grant_q) begin
                    if (hold_cnt_q < HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end else begin
                    last_grant_q <= grant1;
                    hold_cnt_q   <= 4'd1;
                end
            end
            // Read with write also asserted is a write; no data returns.
            rd_vld_q   <= grant_any & sel_read & ~sel_write;
            rd_owner_q <= grant1;
        end
    end

    assign m0_waitrequest = mem_reset_req | (req0 & ~grant0);
    assign m1_waitrequest = mem_reset_req | (req1 & ~grant1);

    assign mem_chipselect = grant_any;
    assign mem_write      = grant_any & sel_write;
    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_vld_q & rd_owner_q;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb/tb_onchip_memory_arbiter.sv - scoreboard bench for onchip_memory_arbiter
module tb_onchip_memory_arbiter;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, mem_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, mem_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, mem_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              mem_chipselect, mem_write, mem_clken, mem_reset_req;

    always #5 clk = ~clk;

    onchip_memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
    );

    // Single-port RAM: registered address, unregistered data out.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_addr_q;
    bit                ram_ready;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= '0;
            ram_addr_q <= '0;
            ram_ready  <= 1'b1;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic              owner;
        logic [DATA_W-1:0] data;
    } rsp_t;

    cmd_t q0[$], q1[$];
    cmd_t cur0, cur1;
    rsp_t exp_q[$];
    bit   grant_log[$];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] last_rd0, last_rd1;

    int n_vec = 0;
    int n_err = 0;
    int m_owner, m_streak, sync_cnt, reset_hold;
    bit random_mode, reset_after_read;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input bit rd, input bit wr, input int addr,
                                input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = ADDR_W'(addr); c.be = be; c.data = data;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        int k;
        k = $urandom_range(0, 9);
        return mk((k >= 3 && k <= 5) || k == 9, k >= 6, $urandom_range(0, 31),
                  BE_W'($urandom_range(1, 15)), $urandom());
    endfunction

    // One bus cycle: present requests, predict the arbitration from the
    // round-robin rules, and compare the DUT's combinational response.
    task automatic step();
        bit   r0, r1, g0, g1, ready;
        cmd_t gc = '0;
        @(negedge clk);
        if (reset_hold > 0) begin
            reset_hold--;
            if (reset_hold == 0) reset_n = 1'b1;
        end
        if (!(cur0.rd || cur0.wr)) cur0 = (q0.size() > 0) ? q0.pop_front() : (random_mode ? rand_cmd() : '0);
        if (!(cur1.rd || cur1.wr)) cur1 = (q1.size() > 0) ? q1.pop_front() : (random_mode ? rand_cmd() : '0);
        m0_read = cur0.rd; m0_write = cur0.wr; m0_address = cur0.addr;
        m0_byteenable = cur0.be; m0_writedata = cur0.data;
        m1_read = cur1.rd; m1_write = cur1.wr; m1_address = cur1.addr;
        m1_byteenable = cur1.be; m1_writedata = cur1.data;
        #2;
        ready = (sync_cnt >= 2);
        r0 = cur0.rd | cur0.wr;
        r1 = cur1.rd | cur1.wr;
        g0 = 1'b0;
        g1 = 1'b0;
        if (ready) begin
            if (r0 && r1) begin
                if (m_streak >= MAX_HOLD) begin g0 = (m_owner == 1); g1 = (m_owner == 0); end
                else                      begin g0 = (m_owner == 0); g1 = (m_owner == 1); end
            end else begin
                g0 = r0;
                g1 = r1;
            end
        end
        check("m0_waitrequest", 32'(m0_waitrequest), 32'(ready ? (r0 & ~g0) : 1'b1));
        check("m1_waitrequest", 32'(m1_waitrequest), 32'(ready ? (r1 & ~g1) : 1'b1));
        check("mem_clken", 32'(mem_clken), 32'(ready));
        check("mem_chipselect", 32'(mem_chipselect), 32'(g0 | g1));
        if (ready) begin
            if (r0 && !m0_waitrequest) grant_log.push_back(1'b0);
            if (r1 && !m1_waitrequest) grant_log.push_back(1'b1);
        end
        if (g0 || g1) begin
            gc = g1 ? cur1 : cur0;
            check("mem_write", 32'(mem_write), 32'(gc.wr));
            check("mem_address", 32'(mem_address), 32'(gc.addr));
            if (gc.wr) begin
                check("mem_byteenable", 32'(mem_byteenable), 32'(gc.be));
                check("mem_writedata", mem_writedata, gc.data);
                for (int b = 0; b < BE_W; b++)
                    if (gc.be[b]) ref_mem[gc.addr][8*b +: 8] = gc.data[8*b +: 8];
            end else begin
                exp_q.push_back({g1, ref_mem[gc.addr]});
            end
            if (int'(g1) == m_owner) m_streak++;
            else begin m_owner = int'(g1); m_streak = 1; end
            if (g0) cur0 = '0;
            if (g1) cur1 = '0;
        end else begin
            check("mem_write_idle", 32'(mem_write), 32'd0);
        end
        @(posedge clk);
        if (reset_n && sync_cnt < 2) sync_cnt++;
        if (reset_after_read && (g0 || g1) && gc.rd && !gc.wr) begin
            #1;
            reset_n = 1'b0;
            exp_q.delete();
            m_owner = 1; m_streak = MAX_HOLD; sync_cnt = 0;
            reset_hold = 3;
            reset_after_read = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cur0.rd || cur0.wr || cur1.rd || cur1.wr) && n < 200) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 32'(n < 200), 32'd1);
        step();
    endtask

    // Monitor: a read granted in one cycle must return on the next.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("readdatavalid", 32'({m1_readdatavalid, m0_readdatavalid}), e.owner ? 32'd2 : 32'd1);
                check("readdata", e.owner ? m1_readdata : m0_readdata, e.data);
                if (e.owner) last_rd1 = m1_readdata;
                else         last_rd0 = m0_readdata;
            end else begin
                check("readdatavalid_idle", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        cur0 = '0; cur1 = '0;
        m_owner = 1; m_streak = MAX_HOLD; sync_cnt = 0; reset_hold = 3;
        random_mode = 1'b0; reset_after_read = 1'b0;
        last_rd0 = '0; last_rd1 = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;

        // Both masters stalled through reset, then continuous contended reads.
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(1'b1, 1'b0, i, 4'hF, '0));
            q1.push_back(mk(1'b1, 1'b0, 16 + i, 4'hF, '0));
        end
        grant_log.delete();
        drain("contention");
        check("contention_len", 32'(grant_log.size()), 32'd24);
        for (int i = 0; i < 24 && i < grant_log.size(); i++)
            check("contention_order", 32'(grant_log[i]), 32'((i / MAX_HOLD) % 2));

        q0.push_back(mk(1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF));
        q0.push_back(mk(1'b1, 1'b0, 16'h0010, 4'hF, '0));
        drain("single");
        check("single_readback", last_rd0, 32'hDEADBEEF);

        q0.push_back(mk(1'b0, 1'b1, 16'h0030, 4'hF, 32'h11223344));
        q0.push_back(mk(1'b0, 1'b1, 16'h0030, 4'b0101, 32'hAABBCCDD));
        q0.push_back(mk(1'b1, 1'b0, 16'h0030, 4'hF, '0));
        drain("bytelanes");
        check("bytelane_merge", last_rd0, 32'h11BB33DD);

        q1.push_back(mk(1'b1, 1'b1, 16'h0020, 4'hF, 32'h5A5A5A5A));
        q0.push_back('0);
        q0.push_back('0);
        q0.push_back(mk(1'b1, 1'b0, 16'h0020, 4'hF, '0));
        drain("readwrite");
        check("readwrite_stored", last_rd0, 32'h5A5A5A5A);

        random_mode = 1'b1;
        repeat (600) step();
        reset_after_read = 1'b1;
        n = 0;
        while (reset_after_read && n < 500) begin step(); n++; end
        check("midread_reset_seen", 32'(reset_after_read), 32'd0);
        repeat (200) step();
        random_mode = 1'b0;
        drain("final");
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
